operand_select_pipe: RTL and testbench
======================================

Name: operand_select_pipe

Overview:
- Registered, parametrised successor to the operand-A source mux in the execute path.
- Decodes a one-hot opcode vector into a source choice: RS1 data, RS2 data, immediate, or zero.
- Latches the chosen operand plus a sideband tag into a 2-entry skid buffer with valid/ready handshakes on both sides.
- Flags and counts illegal select vectors instead of silently holding the last value.

Parameters:
- DATA_W, 32: operand width.
- NUM_OPS, 20: width of the one-hot opcode select vector.
- TAG_W, 5: width of the sideband tag (destination register index), passed through unchanged.
- RS1_MASK, 20'hC17F7: opcode bits that select rs1_data (ADD, SUB, LOAD, SGE, SLE, SEQ, SLI, SRI, ADDI, SUBI, MOVE, ADDF, MULF).
- RS2_MASK, 20'h00008: opcode bits that select rs2_data (STORE).
- IMM_MASK, 20'h00000: opcode bits that select imm_data.
- ZERO_MASK, 20'h02800: opcode bits that select constant 0 (NOP, MOVEI).
- CNT_W, 8: width of the illegal-select counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream operand request valid.
- in_ready  output  1  stage can accept a request this cycle.
- select  input  NUM_OPS  one-hot opcode decode.
- rs1_data  input  DATA_W  register file read port 1.
- rs2_data  input  DATA_W  register file read port 2.
- imm_data  input  DATA_W  sign-extended immediate.
- rs1_addr  input  TAG_W  source index of rs1_data (used only with forwarding).
- in_tag  input  TAG_W  sideband tag.
- out_valid  output  1  out_operand is valid.
- out_ready  input  1  downstream accepts.
- out_operand  output  DATA_W  selected operand.
- out_tag  output  TAG_W  tag matching out_operand.
- out_illegal  output  1  entry was produced from an illegal select.
- illegal_cnt  output  CNT_W  saturating count of illegal selects accepted.
- fwd_valid, fwd_addr[TAG_W], fwd_data[DATA_W]  input  forwarding port; present only with OPSEL_FWD_EN.

Behaviour:
- Single clock domain (clk); reset is synchronous and active-high.
- Reset: buffer count=0, out_valid=0, out_operand=0, out_tag=0, out_illegal=0, illegal_cnt=0. While reset is high, in_ready=0 and all pushes/pops are ignored. Reset mid-transfer discards buffered entries.
- Push when in_valid && in_ready. Pop when out_valid && out_ready.
- in_ready = (count < 2) && !reset, derived from registered count only (no combinational path from out_ready).
- Latency 1 cycle: data pushed in cycle N is visible on out_* in cycle N+1 when the buffer was empty. Otherwise it appears after the older entry pops; order is strictly FIFO.
- Source decode (combinational on push data):
  - legal = exactly one bit of select set AND that bit lies in RS1|RS2|IMM|ZERO mask.
  - Priority if masks overlap: RS1 > RS2 > IMM > ZERO.
  - Illegal (zero bits, multiple bits, or unmapped bit): operand=0, illegal bit=1.
- illegal_cnt increments by 1 on each push with an illegal select and saturates at all-ones (no wrap).
- Simultaneous push and pop:
  - count=1: count stays 1; the new entry replaces the popped one.
  - count=2: push is blocked by in_ready=0; pop only, count becomes 1.
- Buffer states by count: EMPTY(0), ONE(1), FULL(2).
  - EMPTY → ONE on push.
  - ONE → FULL on push without pop.
  - ONE → EMPTY on pop without push.
  - FULL → ONE on pop.
- Holding rule: out_operand/out_tag/out_illegal remain stable while out_valid && !out_ready.

Optional Feature:
- Macro: OPSEL_FWD_EN.
- Defined:
  - Forwarding ports exist.
  - On push, if fwd_valid && fwd_addr==rs1_addr && fwd_addr!=0 and the decode picks RS1, fwd_data replaces rs1_data.
  - Comparison happens in the push cycle only; buffered entries are not updated.
- Undefined: forwarding ports absent; rs1_data is always used; rs1_addr is ignored.

Test Plan:
- Reset then push select=20'h00001, rs1_data=32'h1234_5678, in_tag=3, out_ready=1 → next cycle out_valid=1, out_operand=32'h1234_5678, out_tag=3, out_illegal=0.
- Push select=20'h00008 (STORE), rs2_data=32'hDEAD_BEEF → out_operand=32'hDEAD_BEEF. Push select=20'h02000 (MOVEI) → out_operand=0, out_illegal=0.
- Push select=20'h00003, then select=0, then select=20'h04000 → each out_operand=0 with out_illegal=1; illegal_cnt=3. Then 300 illegal pushes → illegal_cnt=255 and holds.
- Hold out_ready=0 and push A, B → in_ready=0 after 2 pushes and a third push is ignored. Raise out_ready → A, then B, in order; in_ready=1 one cycle after the first pop.
- count=1 with push and pop in the same cycle for 10 cycles → out_valid stays 1, each value appears exactly once, no drop or duplicate. Assert reset with count=2 → next cycle out_valid=0, illegal_cnt=0.
- OPSEL_FWD_EN: select=20'h00001, rs1_addr=7, fwd_valid=1, fwd_addr=7, fwd_data=32'hCAFE_0001, rs1_data=32'h1 → out_operand=32'hCAFE_0001. With fwd_addr=0 → 32'h1.

Source files
------------

// File: rtl/operand_select_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : operand_select_pipe
//  Description : Registered operand-A source select for the execute path.
//                A one-hot opcode vector picks RS1, RS2, immediate or zero.
//                The chosen operand and its sideband tag enter a 2-entry
//                skid buffer with valid/ready handshakes on both sides.
//                Illegal select vectors yield a zero operand, are flagged
//                on the entry, and are counted in a saturating counter.
//  Options     : OPSEL_FWD_EN - adds a single-source forwarding port that
//                can override rs1_data in the push cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module operand_select_pipe #(
    parameter int                   DATA_W    = 32,
    parameter int                   NUM_OPS   = 20,
    parameter int                   TAG_W     = 5,
    parameter logic [NUM_OPS-1:0]   RS1_MASK  = 20'hC17F7,
    parameter logic [NUM_OPS-1:0]   RS2_MASK  = 20'h00008,
    parameter logic [NUM_OPS-1:0]   IMM_MASK  = 20'h00000,
    parameter logic [NUM_OPS-1:0]   ZERO_MASK = 20'h02800,
    parameter int                   CNT_W     = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [NUM_OPS-1:0]  select,
    input  logic [DATA_W-1:0]   rs1_data,
    input  logic [DATA_W-1:0]   rs2_data,
    input  logic [DATA_W-1:0]   imm_data,
    input  logic [TAG_W-1:0]    rs1_addr,
    input  logic [TAG_W-1:0]    in_tag,
`ifdef OPSEL_FWD_EN
    input  logic                fwd_valid,
    input  logic [TAG_W-1:0]    fwd_addr,
    input  logic [DATA_W-1:0]   fwd_data,
`endif
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_operand,
    output logic [TAG_W-1:0]    out_tag,
    output logic                out_illegal,
    output logic [CNT_W-1:0]    illegal_cnt
);

    localparam logic [NUM_OPS-1:0] c_sel_one   = NUM_OPS'(1);
    localparam logic [NUM_OPS-1:0] c_any_mask  = RS1_MASK | RS2_MASK | IMM_MASK | ZERO_MASK;
    localparam logic [CNT_W-1:0]   c_cnt_max   = '1;
    localparam logic [CNT_W-1:0]   c_cnt_one   = CNT_W'(1);

    // Buffer occupancy: EMPTY(0), ONE(1), FULL(2)
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;

    // Head entry drives the outputs directly; tail holds the younger entry.
    logic [DATA_W-1:0]      r_head_op;
    logic [TAG_W-1:0]       r_head_tag;
    logic                   r_head_ill;
    logic [DATA_W-1:0]      r_tail_op;
    logic [TAG_W-1:0]       r_tail_tag;
    logic                   r_tail_ill;
    logic [CNT_W-1:0]       r_illegal_cnt;

    logic                   w_push;
    logic                   w_pop;
    logic                   w_one_hot;
    logic                   w_mapped;
    logic                   w_legal;
    logic [DATA_W-1:0]      w_rs1_src;
    logic [DATA_W-1:0]      w_new_op;

    // Handshake terms; in_ready depends only on registered occupancy
    assign in_ready  = (r_state != ST_FULL) && !reset;
    assign out_valid = (r_state != ST_EMPTY);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    assign out_operand = r_head_op;
    assign out_tag     = r_head_tag;
    assign out_illegal = r_head_ill;
    assign illegal_cnt = r_illegal_cnt;

`ifdef OPSEL_FWD_EN
    // Forwarded result overrides the register file value for a matching, non-zero index
    always_comb begin
        w_rs1_src = rs1_data;
        if (fwd_valid && (fwd_addr == rs1_addr) && (fwd_addr != '0)) begin
            w_rs1_src = fwd_data;
        end
    end
`else
    // Without forwarding the source index carries no information
    logic w_unused_rs1_addr;
    assign w_unused_rs1_addr = ^rs1_addr;

    // Register file value is always the RS1 source
    always_comb begin
        w_rs1_src = rs1_data;
    end
`endif

    // Source decode: exactly one bit set and that bit must map to a source
    always_comb begin
        w_one_hot = (select != '0) && ((select & (select - c_sel_one)) == '0);
        w_mapped  = |(select & c_any_mask);
        w_legal   = w_one_hot && w_mapped;
        w_new_op  = '0;
        if (w_legal) begin
            if (|(select & RS1_MASK)) begin
                w_new_op = w_rs1_src;
            end else if (|(select & RS2_MASK)) begin
                w_new_op = rs2_data;
            end else if (|(select & IMM_MASK)) begin
                w_new_op = imm_data;
            end else begin
                w_new_op = '0;
            end
        end
    end

    // Occupancy state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Occupancy next-state from push/pop; FULL never sees a push
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_EMPTY: begin
                if (w_push) w_state_next = ST_ONE;
            end
            ST_ONE: begin
                if (w_push && !w_pop)      w_state_next = ST_FULL;
                else if (!w_push && w_pop) w_state_next = ST_EMPTY;
            end
            ST_FULL: begin
                if (w_pop) w_state_next = ST_ONE;
            end
            default: w_state_next = ST_EMPTY;
        endcase
    end

    // Entry storage; the head only changes on a push into an empty slot or a pop
    always_ff @(posedge clk) begin
        if (reset) begin
            r_head_op  <= '0;
            r_head_tag <= '0;
            r_head_ill <= 1'b0;
            r_tail_op  <= '0;
            r_tail_tag <= '0;
            r_tail_ill <= 1'b0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_push) begin
                        r_head_op  <= w_new_op;
                        r_head_tag <= in_tag;
                        r_head_ill <= !w_legal;
                    end
                end
                ST_ONE: begin
                    if (w_push && w_pop) begin
                        r_head_op  <= w_new_op;
                        r_head_tag <= in_tag;
                        r_head_ill <= !w_legal;
                    end else if (w_push) begin
                        r_tail_op  <= w_new_op;
                        r_tail_tag <= in_tag;
                        r_tail_ill <= !w_legal;
                    end
                end
                ST_FULL: begin
                    if (w_pop) begin
                        r_head_op  <= r_tail_op;
                        r_head_tag <= r_tail_tag;
                        r_head_ill <= r_tail_ill;
                    end
                end
                default: begin
                    r_head_op  <= '0;
                    r_head_tag <= '0;
                    r_head_ill <= 1'b0;
                end
            endcase
        end
    end

    // Saturating count of accepted illegal selects
    always_ff @(posedge clk) begin
        if (reset) begin
            r_illegal_cnt <= '0;
        end else if (w_push && !w_legal && (r_illegal_cnt != c_cnt_max)) begin
            r_illegal_cnt <= r_illegal_cnt + c_cnt_one;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_operand_select_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_operand_select_pipe
//  Description : Directed self-checking bench for operand_select_pipe.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_operand_select_pipe;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [19:0] select;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm_data;
    logic [4:0]  rs1_addr;
    logic [4:0]  in_tag;
`ifdef OPSEL_FWD_EN
    logic        fwd_valid;
    logic [4:0]  fwd_addr;
    logic [31:0] fwd_data;
`endif
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_operand;
    logic [4:0]  out_tag;
    logic        out_illegal;
    logic [7:0]  illegal_cnt;

    int n_cmp = 0;
    int n_err = 0;

    operand_select_pipe dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .select      (select),
        .rs1_data    (rs1_data),
        .rs2_data    (rs2_data),
        .imm_data    (imm_data),
        .rs1_addr    (rs1_addr),
        .in_tag      (in_tag),
`ifdef OPSEL_FWD_EN
        .fwd_valid   (fwd_valid),
        .fwd_addr    (fwd_addr),
        .fwd_data    (fwd_data),
`endif
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_operand (out_operand),
        .out_tag     (out_tag),
        .out_illegal (out_illegal),
        .illegal_cnt (illegal_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle past the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        select    = '0;
        rs1_data  = '0;
        rs2_data  = '0;
        imm_data  = 32'h0000_0FFF;
        rs1_addr  = '0;
        in_tag    = '0;
        out_ready = 1'b1;
`ifdef OPSEL_FWD_EN
        fwd_valid = 1'b0;
        fwd_addr  = '0;
        fwd_data  = '0;
`endif
        step();
        in_valid = 1'b1;            // ignored while in reset
        select   = 20'h00001;
        step();
        chk("rst_in_ready",  in_ready,    0);
        chk("rst_out_valid", out_valid,   0);
        chk("rst_operand",   out_operand, 0);
        chk("rst_tag",       out_tag,     0);
        chk("rst_illegal",   out_illegal, 0);
        chk("rst_cnt",       illegal_cnt, 0);
        in_valid = 1'b0;
        reset    = 1'b0;
        #1;
        chk("post_rst_in_ready", in_ready, 1);

        // ADD selects rs1
        in_valid = 1'b1; select = 20'h00001; rs1_data = 32'h1234_5678;
        rs2_data = 32'h5555_5555; in_tag = 5'd3;
        step();
        chk("add_valid",   out_valid,   1);
        chk("add_operand", out_operand, 32'h1234_5678);
        chk("add_tag",     out_tag,     3);
        chk("add_illegal", out_illegal, 0);

        // STORE selects rs2
        select = 20'h00008; rs2_data = 32'hDEAD_BEEF; in_tag = 5'd4;
        step();
        chk("store_operand", out_operand, 32'hDEAD_BEEF);
        chk("store_tag",     out_tag,     4);

        // MOVEI selects zero, legal
        select = 20'h02000; in_tag = 5'd5;
        step();
        chk("movei_operand", out_operand, 0);
        chk("movei_illegal", out_illegal, 0);

        // Illegal: two bits, none, unmapped bit
        select = 20'h00003;
        step();
        chk("ill_multi_op",  out_operand, 0);
        chk("ill_multi_flg", out_illegal, 1);
        select = 20'h00000;
        step();
        chk("ill_zero_op",   out_operand, 0);
        chk("ill_zero_flg",  out_illegal, 1);
        select = 20'h04000;
        step();
        chk("ill_unmap_op",  out_operand, 0);
        chk("ill_unmap_flg", out_illegal, 1);
        chk("ill_cnt3",      illegal_cnt, 3);

        // Saturation: 300 more illegal pushes
        select = 20'h00000;
        for (int i = 0; i < 300; i++) step();
        chk("ill_cnt_sat", illegal_cnt, 255);
        step();
        chk("ill_cnt_hold", illegal_cnt, 255);
        in_valid = 1'b0;
        step();
        chk("drain_empty", out_valid, 0);
        chk("drain_cnt",   illegal_cnt, 255);

        // Backpressure: A, B fill the buffer, C is refused
        out_ready = 1'b0;
        in_valid = 1'b1; select = 20'h00001; rs1_data = 32'hAAAA_0001; in_tag = 5'd1;
        step();
        chk("bp_a_valid", out_valid,   1);
        chk("bp_a_op",    out_operand, 32'hAAAA_0001);
        chk("bp_a_ready", in_ready,    1);
        rs1_data = 32'hBBBB_0002; in_tag = 5'd2;
        step();
        chk("bp_full_ready", in_ready,    0);
        chk("bp_hold_op",    out_operand, 32'hAAAA_0001);
        rs1_data = 32'hCCCC_0003; in_tag = 5'd9;
        step();
        chk("bp_c_blocked", in_ready,    0);
        chk("bp_c_hold_op", out_operand, 32'hAAAA_0001);
        chk("bp_c_hold_tg", out_tag,     1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("bp_pop_a_op", out_operand, 32'hAAAA_0001);
        step();
        chk("bp_b_op",    out_operand, 32'hBBBB_0002);
        chk("bp_b_tag",   out_tag,     2);
        chk("bp_b_ready", in_ready,    1);
        step();
        chk("bp_no_c", out_valid, 0);

        // Streaming at count=1: push and pop every cycle
        in_valid = 1'b1; select = 20'h00001; rs1_data = 32'h0000_1000; in_tag = 5'd0;
        step();
        chk("str_first", out_operand, 32'h0000_1000);
        for (int i = 1; i <= 10; i++) begin
            rs1_data = 32'h0000_1000 + 32'(i);
            in_tag   = 5'(i);
            step();
            chk("str_valid", out_valid,   1);
            chk("str_op",    out_operand, 32'h0000_1000 + 32'(i));
            chk("str_tag",   out_tag,     5'(i));
        end
        in_valid = 1'b0;
        step();
        chk("str_drained", out_valid, 0);

        // Reset with a full buffer discards both entries
        out_ready = 1'b0;
        in_valid = 1'b1; select = 20'h00000;
        step();
        step();
        chk("rf_full", in_ready, 0);
        in_valid = 1'b0;
        reset    = 1'b1;
        step();
        chk("rf_valid", out_valid,   0);
        chk("rf_cnt",   illegal_cnt, 0);
        chk("rf_ready", in_ready,    0);
        reset     = 1'b0;
        out_ready = 1'b1;
        step();
        chk("rf_after", out_valid, 0);

`ifdef OPSEL_FWD_EN
        in_valid = 1'b1; select = 20'h00001; rs1_data = 32'h1; rs1_addr = 5'd7;
        fwd_valid = 1'b1; fwd_addr = 5'd7; fwd_data = 32'hCAFE_0001;
        step();
        chk("fwd_hit", out_operand, 32'hCAFE_0001);
        fwd_addr = 5'd0; rs1_addr = 5'd0;
        step();
        chk("fwd_zero", out_operand, 32'h1);
        in_valid = 1'b0; fwd_valid = 1'b0;
        step();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
